gpu_frame_scheduler: RTL

Sequences one frame through the GPU core. It streams host vertex words into the core's vertex memory write port and double-buffers the 4x4 transform matrix (shadow and active copies). It pulses `start` once the core is idle and tracks `frame_end` to report completion. It sits between the host/DMA interface and the GPU core and is the only driver of the core's start, vertex_count, matrix and memory-write inputs.

---
 rtl/gpu_pkg.sv | 34 +++
 rtl/gpu_frame_scheduler_mat_dbuf.sv | 39 +++
 rtl/gpu_frame_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU frame scheduler: fixed-point word,
// 4x4 matrix and scheduler state encoding.
package gpu_pkg;

  localparam int M     = 11;
  localparam int N     = 7;
  localparam int W     = M + N;
  localparam int DEPTH = 16384;
  localparam int AW    = $clog2(DEPTH);
  // Vertex counts reach DEPTH itself, so they need one bit more than an address.
  localparam int CW    = AW + 1;

  typedef logic signed [W-1:0] fixed_t;
  typedef fixed_t [0:15] mat4_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ARM      = 3'd2,
    S_START    = 3'd3,
    S_WAIT_LOW = 3'd4,
    S_WAIT_END = 3'd5,
    S_DONE     = 3'd6
  } sched_state_t;

  // Requested count limited to the memory depth and rounded down to whole vertices of 4 words.
  function automatic logic [CW-1:0] clamp_count(input logic [31:0] req);
    logic [CW-1:0] c;
    if (req > 32'(DEPTH)) c = CW'(DEPTH);
    else                  c = req[CW-1:0];
    return c & ~CW'(3);
  endfunction

endpackage

// File: rtl/gpu_frame_scheduler_mat_dbuf.sv
// Double-buffered 4x4 transform matrix: host writes the shadow copy, a swap
// moves it (including any same-cycle write) into the active copy.
module mat_dbuf
  import gpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  fixed_t     wr_data,
  input  logic       commit,
  input  logic       swap,
  output mat4_t      active,
  output logic       pending
);

  mat4_t shadow;
  mat4_t shadow_next;

  always_comb begin
    shadow_next = shadow;
    if (wr_en) shadow_next[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      shadow <= shadow_next;
      if (swap) active <= shadow_next;
      // A swap consumes any commit, including one arriving in the same cycle.
      if (swap)        pending <= 1'b0;
      else if (commit) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/gpu_frame_scheduler.sv
// Frame sequencer between host/DMA and the GPU core: streams vertex words,
// double-buffers the matrix, starts the core and reports completion.
// Optional feature macro: AUTO_REPEAT_EN (adds auto_repeat input).
//
// Stream handshake: a vertex word transfers on a rising clk edge where
// vtx_in_valid and vtx_in_ready are both 1; ready is high only in LOAD and
// depends on state alone, never on valid.
module gpu_frame_scheduler
  import gpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cfg_vertex_count,
  input  logic             kick,
  input  logic [W-1:0]     vtx_in_data,
  input  logic             vtx_in_valid,
  output logic             vtx_in_ready,
  input  logic             vtx_in_last,
  input  logic             mat_wr_en,
  input  logic [3:0]       mat_wr_idx,
  input  logic [W-1:0]     mat_wr_data,
  input  logic             mat_commit,
  output logic             gpu_mem_wr_en,
  output logic [AW-1:0]    gpu_mem_wr_addr,
  output logic [W-1:0]     gpu_mem_wr_data,
  output logic [31:0]      gpu_vertex_count,
  output logic             gpu_start,
  output mat4_t            gpu_transform_matrix,
  input  logic             gpu_frame_end,
`ifdef AUTO_REPEAT_EN
  input  logic             auto_repeat,
`endif
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frames_rendered,
  output logic             load_err,
  output sched_state_t     state_dbg
);

  sched_state_t  state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] wr_cnt, wr_cnt_next;
  logic [CW-1:0] wr_cnt_inc;
  logic [CW-1:0] trunc_cnt;
  logic          load_err_next;
  logic          accept;
  logic          swap;
  logic          pending;

  assign wr_cnt_inc = wr_cnt + CW'(1);
  assign trunc_cnt  = wr_cnt_inc & ~CW'(3);
  assign accept     = vtx_in_valid & vtx_in_ready;
  assign state_dbg  = state;

  mat_dbuf u_mat_dbuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mat_wr_en),
    .wr_idx  (mat_wr_idx),
    .wr_data (fixed_t'(mat_wr_data)),
    .commit  (mat_commit),
    .swap    (swap),
    .active  (gpu_transform_matrix),
    .pending (pending)
  );

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    wr_cnt_next   = wr_cnt;
    load_err_next = load_err;
    vtx_in_ready  = 1'b0;
    gpu_start     = 1'b0;
    frame_done    = 1'b0;
    swap          = 1'b0;
    busy          = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        // Between frames the core is not reading the matrix, so commits land at once.
        swap = mat_commit;
        if (kick) begin
          cnt_next = clamp_count(cfg_vertex_count);
          if (clamp_count(cfg_vertex_count) == '0) begin
            load_err_next = 1'b1;
          end else begin
            load_err_next = 1'b0;
            wr_cnt_next   = '0;
            state_next    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        vtx_in_ready = 1'b1;
        if (vtx_in_valid) begin
          wr_cnt_next = wr_cnt_inc;
          if (wr_cnt_inc == cnt) begin
            state_next = S_ARM;
          end else if (vtx_in_last) begin
            load_err_next = 1'b1;
            cnt_next      = trunc_cnt;
            state_next    = (trunc_cnt == '0) ? S_IDLE : S_ARM;
          end
        end
      end
      S_ARM: begin
        if (gpu_frame_end) begin
          // Swap on entry to START so the new matrix is already presented with the pulse.
          swap       = pending | mat_commit;
          state_next = S_START;
        end
      end
      S_START: begin
        gpu_start  = 1'b1;
        state_next = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!gpu_frame_end) state_next = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (gpu_frame_end) state_next = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
`ifdef AUTO_REPEAT_EN
        state_next = auto_repeat ? S_ARM : S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      wr_cnt           <= '0;
      load_err         <= 1'b0;
      gpu_mem_wr_en    <= 1'b0;
      gpu_mem_wr_addr  <= '0;
      gpu_mem_wr_data  <= '0;
      gpu_vertex_count <= '0;
      frames_rendered  <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      wr_cnt        <= wr_cnt_next;
      load_err      <= load_err_next;
      gpu_mem_wr_en <= accept;
      if (accept) begin
        gpu_mem_wr_addr <= wr_cnt[AW-1:0];
        gpu_mem_wr_data <= vtx_in_data;
      end
      // Count is published once on entering ARM and then held until a later load.
      if (state == S_LOAD && state_next == S_ARM)
        gpu_vertex_count <= 32'(cnt_next);
      if (state == S_DONE)
        frames_rendered <= frames_rendered + CNT_W'(1);
    end
  end

endmodule
